// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter that picks up to WAYS completing functional units per
// cycle and broadcasts their results on WAYS registered common-data-bus lanes.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   squash            pipeline flush: no grants, CDB lanes cleared next edge
//   fu_req            per-FU completion request
//   fu_ROB_idx ..     per-FU payload, flattened (FU i at [i*W +: W])
//   fu_target
//   fu_ack            combinational grant; payload consumed this cycle
//   CDB_valid ..      registered lane valid and payloads, flattened by lane
//   CDB_target
//   rr_ptr            current round-robin scan start index
// -----------------------------------------------------------------------------
`ifndef WAYS
`define WAYS 3
`endif
`ifndef ROB
`define ROB 32
`endif
`ifndef PRF
`define PRF 64
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
   parameter int NUM_FU = 6,
   parameter int WAYS   = `WAYS,
   parameter int ROB    = `ROB,
   parameter int PRF    = `PRF,
   parameter int XLEN   = `XLEN,
   localparam int ROB_W = $clog2(ROB),
   localparam int PRN_W = $clog2(PRF),
   localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     squash,
   input  logic [NUM_FU-1:0]        fu_req,
   input  logic [NUM_FU*ROB_W-1:0]  fu_ROB_idx,
   input  logic [NUM_FU*PRN_W-1:0]  fu_dest_PRN,
   input  logic [NUM_FU*XLEN-1:0]   fu_value,
   input  logic [NUM_FU-1:0]        fu_direction,
   input  logic [NUM_FU*XLEN-1:0]   fu_target,
   output logic [NUM_FU-1:0]        fu_ack,
   output logic [WAYS-1:0]          CDB_valid,
   output logic [WAYS*ROB_W-1:0]    CDB_ROB_idx,
   output logic [WAYS*PRN_W-1:0]    CDB_dest_PRN,
   output logic [WAYS*XLEN-1:0]     CDB_value,
   output logic [WAYS-1:0]          CDB_direction,
   output logic [WAYS*XLEN-1:0]     CDB_target,
   output logic [RR_W-1:0]          rr_ptr
);

   localparam int CNT_W  = $clog2(WAYS + 1);
   localparam int LANE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [RR_W:0]    NUM_FU_C = (RR_W + 1)'(NUM_FU);
   localparam logic [CNT_W-1:0] WAYS_C   = CNT_W'(WAYS);

   // per-FU payload views
   logic [ROB_W-1:0] rob_a [NUM_FU];
   logic [PRN_W-1:0] prn_a [NUM_FU];
   logic [XLEN-1:0]  val_a [NUM_FU];
   logic [XLEN-1:0]  tgt_a [NUM_FU];

   // per-lane next-state values
   logic             lane_valid_s [WAYS];
   logic [ROB_W-1:0] lane_rob_s   [WAYS];
   logic [PRN_W-1:0] lane_prn_s   [WAYS];
   logic [XLEN-1:0]  lane_val_s   [WAYS];
   logic             lane_dir_s   [WAYS];
   logic [XLEN-1:0]  lane_tgt_s   [WAYS];

   logic [NUM_FU-1:0] ack_s;
   logic [CNT_W-1:0]  cnt_s;
   logic [LANE_W-1:0] lane_s;
   logic [RR_W:0]     pos_s;
   logic [RR_W-1:0]   idx_s;
   logic [RR_W-1:0]   last_s;
   logic [RR_W:0]     nxt_s;

   logic [RR_W-1:0]        rr_ptr_q,    rr_ptr_d;
   logic [WAYS-1:0]        cdb_valid_q, cdb_valid_d;
   logic [WAYS*ROB_W-1:0]  cdb_rob_q,   cdb_rob_d;
   logic [WAYS*PRN_W-1:0]  cdb_prn_q,   cdb_prn_d;
   logic [WAYS*XLEN-1:0]   cdb_val_q,   cdb_val_d;
   logic [WAYS-1:0]        cdb_dir_q,   cdb_dir_d;
   logic [WAYS*XLEN-1:0]   cdb_tgt_q,   cdb_tgt_d;

   // Unflatten FU payload buses into indexable arrays
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         rob_a[i] = fu_ROB_idx[i*ROB_W +: ROB_W];
         prn_a[i] = fu_dest_PRN[i*PRN_W +: PRN_W];
         val_a[i] = fu_value[i*XLEN +: XLEN];
         tgt_a[i] = fu_target[i*XLEN +: XLEN];
      end
   end

   // Circular scan from rr_ptr: grant the first WAYS requesters, k-th grant on lane k
   always_comb begin
      ack_s  = '0;
      cnt_s  = '0;
      lane_s = '0;
      pos_s  = '0;
      idx_s  = '0;
      last_s = rr_ptr_q;
      for (int w = 0; w < WAYS; w++) begin
         lane_valid_s[w] = 1'b0;
         lane_rob_s[w]   = '0;
         lane_prn_s[w]   = '0;
         lane_val_s[w]   = '0;
         lane_dir_s[w]   = 1'b0;
         lane_tgt_s[w]   = '0;
      end
      for (int k = 0; k < NUM_FU; k++) begin
         // rr_ptr + k never exceeds 2*NUM_FU-2, so one subtraction wraps it
         pos_s = {1'b0, rr_ptr_q} + (RR_W + 1)'(k);
         if (pos_s >= NUM_FU_C) begin
            pos_s = pos_s - NUM_FU_C;
         end else begin
            pos_s = pos_s;
         end
         idx_s = pos_s[RR_W-1:0];
         if (!squash && fu_req[idx_s] && (cnt_s < WAYS_C)) begin
            lane_s               = cnt_s[LANE_W-1:0];
            ack_s[idx_s]         = 1'b1;
            lane_valid_s[lane_s] = 1'b1;
            lane_rob_s[lane_s]   = rob_a[idx_s];
            lane_prn_s[lane_s]   = prn_a[idx_s];
            lane_val_s[lane_s]   = val_a[idx_s];
            lane_dir_s[lane_s]   = fu_direction[idx_s];
            lane_tgt_s[lane_s]   = tgt_a[idx_s];
            cnt_s                = cnt_s + CNT_W'(1);
            last_s               = idx_s;
         end else begin
            cnt_s = cnt_s;
         end
      end
   end

   // Next scan start: one past the last granted FU, held when nothing was granted
   always_comb begin
      nxt_s = {1'b0, last_s} + (RR_W + 1)'(1);
      if (nxt_s >= NUM_FU_C) begin
         nxt_s = '0;
      end else begin
         nxt_s = nxt_s;
      end
      if (cnt_s != '0) begin
         rr_ptr_d = nxt_s[RR_W-1:0];
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Pack lane values into flattened next-state buses
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         cdb_valid_d[w]                = lane_valid_s[w];
         cdb_rob_d[w*ROB_W +: ROB_W]   = lane_rob_s[w];
         cdb_prn_d[w*PRN_W +: PRN_W]   = lane_prn_s[w];
         cdb_val_d[w*XLEN +: XLEN]     = lane_val_s[w];
         cdb_dir_d[w]                  = lane_dir_s[w];
         cdb_tgt_d[w*XLEN +: XLEN]     = lane_tgt_s[w];
      end
   end

   // Round-robin pointer and CDB lane registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= '0;
         cdb_rob_q   <= '0;
         cdb_prn_q   <= '0;
         cdb_val_q   <= '0;
         cdb_dir_q   <= '0;
         cdb_tgt_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_rob_q   <= cdb_rob_d;
         cdb_prn_q   <= cdb_prn_d;
         cdb_val_q   <= cdb_val_d;
         cdb_dir_q   <= cdb_dir_d;
         cdb_tgt_q   <= cdb_tgt_d;
      end
   end

   // Grants are suppressed while reset is held, even though the scan still runs
   assign fu_ack        = ack_s & {NUM_FU{reset}};
   assign CDB_valid     = cdb_valid_q;
   assign CDB_ROB_idx   = cdb_rob_q;
   assign CDB_dest_PRN  = cdb_prn_q;
   assign CDB_value     = cdb_val_q;
   assign CDB_direction = cdb_dir_q;
   assign CDB_target    = cdb_tgt_q;
   assign rr_ptr        = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Table-driven bench for cdb_arbiter (NUM_FU=6, WAYS=3): each vector lists the
// expected grants, next rr_ptr and which FU lands on each lane; the expected
// lane contents are queued when stimulus is driven and checked after the edge.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

   localparam int NF = 6;
   localparam int W  = 3;
   localparam int RW = 5;
   localparam int PW = 6;
   localparam int XL = 32;
   localparam int NV = 13;

   logic              clock = 1'b0;
   logic              reset;
   logic              squash;
   logic [NF-1:0]     fu_req;
   logic [NF*RW-1:0]  fu_ROB_idx;
   logic [NF*PW-1:0]  fu_dest_PRN;
   logic [NF*XL-1:0]  fu_value;
   logic [NF-1:0]     fu_direction;
   logic [NF*XL-1:0]  fu_target;
   logic [NF-1:0]     fu_ack;
   logic [W-1:0]      CDB_valid;
   logic [W*RW-1:0]   CDB_ROB_idx;
   logic [W*PW-1:0]   CDB_dest_PRN;
   logic [W*XL-1:0]   CDB_value;
   logic [W-1:0]      CDB_direction;
   logic [W*XL-1:0]   CDB_target;
   logic [2:0]        rr_ptr;

   cdb_arbiter dut (
      .clock(clock), .reset(reset), .squash(squash), .fu_req(fu_req),
      .fu_ROB_idx(fu_ROB_idx), .fu_dest_PRN(fu_dest_PRN), .fu_value(fu_value),
      .fu_direction(fu_direction), .fu_target(fu_target), .fu_ack(fu_ack),
      .CDB_valid(CDB_valid), .CDB_ROB_idx(CDB_ROB_idx), .CDB_dest_PRN(CDB_dest_PRN),
      .CDB_value(CDB_value), .CDB_direction(CDB_direction), .CDB_target(CDB_target),
      .rr_ptr(rr_ptr)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       sq;
      logic [5:0] req;
      logic [5:0] ack;
      logic [2:0] rr;
      logic [8:0] lanes;   // {lane2_fu, lane1_fu, lane0_fu}, 7 = lane idle
   } vec_t;

   typedef struct packed {
      logic [2:0]  valid;
      logic [14:0] rob;
      logic [17:0] prn;
      logic [95:0] val;
      logic [2:0]  dir;
      logic [95:0] tgt;
      logic [2:0]  rr;
   } exp_t;

   vec_t tbl [NV];
   exp_t sb_q [$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic sq, input logic [5:0] req, input logic [5:0] ack,
                               input logic [2:0] rr, input logic [2:0] l0,
                               input logic [2:0] l1, input logic [2:0] l2);
      vec_t t;
      t.sq = sq; t.req = req; t.ack = ack; t.rr = rr; t.lanes = {l2, l1, l0};
      return t;
   endfunction

   // distinct payload per (vector, FU); FU4 of vector 2 carries ROB 17 / PRN 40
   function automatic logic [4:0] f_rob(input int v, input int f);
      if (v == 2 && f == 4) return 5'd17;
      return 5'(v * 7 + f * 3 + 1);
   endfunction
   function automatic logic [5:0] f_prn(input int v, input int f);
      if (v == 2 && f == 4) return 6'd40;
      return 6'(v * 11 + f * 5 + 2);
   endfunction
   function automatic logic [31:0] f_val(input int v, input int f);
      return 32'hA000_0000 + 32'(v * 256 + f);
   endfunction
   function automatic logic f_dir(input int v, input int f);
      return 1'((v + f + 1) % 2);
   endfunction
   function automatic logic [31:0] f_tgt(input int v, input int f);
      return 32'h1000_0000 + 32'(v * 64 + f * 4);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int v, input logic sq, input logic [5:0] req);
      squash = sq;
      fu_req = req;
      for (int f = 0; f < NF; f++) begin
         fu_ROB_idx[f*RW +: RW]  = f_rob(v, f);
         fu_dest_PRN[f*PW +: PW] = f_prn(v, f);
         fu_value[f*XL +: XL]    = f_val(v, f);
         fu_direction[f]         = f_dir(v, f);
         fu_target[f*XL +: XL]   = f_tgt(v, f);
      end
   endtask

   function automatic exp_t build(input int v, input vec_t t);
      exp_t e;
      logic [2:0] fs;
      int f;
      e = '0;
      e.rr = t.rr;
      for (int k = 0; k < W; k++) begin
         fs = t.lanes[3*k +: 3];
         if (fs != 3'd7) begin
            f = int'(fs);
            e.valid[k]        = 1'b1;
            e.rob[5*k +: 5]   = f_rob(v, f);
            e.prn[6*k +: 6]   = f_prn(v, f);
            e.val[32*k +: 32] = f_val(v, f);
            e.dir[k]          = f_dir(v, f);
            e.tgt[32*k +: 32] = f_tgt(v, f);
         end
      end
      return e;
   endfunction

   task automatic check_cdb();
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 128'(1), 128'(0));
      end else begin
         e = sb_q.pop_front();
         chk("cdb_valid", 128'(CDB_valid), 128'(e.valid));
         chk("cdb_rob", 128'(CDB_ROB_idx), 128'(e.rob));
         chk("cdb_prn", 128'(CDB_dest_PRN), 128'(e.prn));
         chk("cdb_value", 128'(CDB_value), 128'(e.val));
         chk("cdb_dir", 128'(CDB_direction), 128'(e.dir));
         chk("cdb_target", 128'(CDB_target), 128'(e.tgt));
         chk("rr_ptr", 128'(rr_ptr), 128'(e.rr));
      end
   endtask

   initial begin
      //             sq    req        ack        rr    lane0 lane1 lane2
      tbl[0]  = mk(1'b0, 6'b111111, 6'b000111, 3'd3, 3'd0, 3'd1, 3'd2);
      tbl[1]  = mk(1'b0, 6'b111111, 6'b111000, 3'd0, 3'd3, 3'd4, 3'd5);
      tbl[2]  = mk(1'b0, 6'b010000, 6'b010000, 3'd5, 3'd4, 3'd7, 3'd7);
      tbl[3]  = mk(1'b0, 6'b101011, 6'b100011, 3'd2, 3'd5, 3'd0, 3'd1);
      tbl[4]  = mk(1'b0, 6'b001000, 6'b001000, 3'd4, 3'd3, 3'd7, 3'd7);
      tbl[5]  = mk(1'b0, 6'b000000, 6'b000000, 3'd4, 3'd7, 3'd7, 3'd7);
      tbl[6]  = mk(1'b1, 6'b000111, 6'b000000, 3'd4, 3'd7, 3'd7, 3'd7);
      tbl[7]  = mk(1'b0, 6'b000111, 6'b000111, 3'd3, 3'd0, 3'd1, 3'd2);
      tbl[8]  = mk(1'b0, 6'b100001, 6'b100001, 3'd1, 3'd5, 3'd0, 3'd7);
      tbl[9]  = mk(1'b0, 6'b000010, 6'b000010, 3'd2, 3'd1, 3'd7, 3'd7);
      tbl[10] = mk(1'b0, 6'b110100, 6'b110100, 3'd0, 3'd2, 3'd4, 3'd5);
      tbl[11] = mk(1'b0, 6'b011110, 6'b001110, 3'd4, 3'd1, 3'd2, 3'd3);
      tbl[12] = mk(1'b0, 6'b011110, 6'b010110, 3'd3, 3'd4, 3'd1, 3'd2);

      // reset asserted with every FU requesting: outputs clear before any clock edge
      reset = 1'b0;
      drive(0, 1'b0, 6'b111111);
      #2;
      chk("rst_ack", 128'(fu_ack), 128'(0));
      chk("rst_valid", 128'(CDB_valid), 128'(0));
      chk("rst_rr", 128'(rr_ptr), 128'(0));
      chk("rst_rob", 128'(CDB_ROB_idx), 128'(0));

      @(negedge clock);
      reset = 1'b1;
      for (int v = 0; v < NV; v++) begin
         if (sb_q.size() > 0) check_cdb();
         drive(v, tbl[v].sq, tbl[v].req);
         #1;
         chk($sformatf("ack_v%0d", v), 128'(fu_ack), 128'(tbl[v].ack));
         sb_q.push_back(build(v, tbl[v]));
         @(negedge clock);
      end
      check_cdb();

      // asynchronous reset in the middle of a full broadcast (rr_ptr is 3 here)
      drive(20, 1'b0, 6'b111111);
      #1;
      chk("pre_ack", 128'(fu_ack), 128'(6'b111000));
      @(negedge clock);
      chk("pre_valid", 128'(CDB_valid), 128'(3'b111));
      chk("pre_rr", 128'(rr_ptr), 128'(0));
      #2;
      reset = 1'b0;
      #1;
      chk("async_valid", 128'(CDB_valid), 128'(0));
      chk("async_rr", 128'(rr_ptr), 128'(0));
      chk("async_ack", 128'(fu_ack), 128'(0));
      chk("async_value", 128'(CDB_value), 128'(0));
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("post_ack", 128'(fu_ack), 128'(6'b000111));
      @(negedge clock);
      chk("post_rr", 128'(rr_ptr), 128'(3));
      chk("post_valid", 128'(CDB_valid), 128'(3'b111));
      chk("post_lane0_rob", 128'(CDB_ROB_idx[4:0]), 128'(f_rob(20, 0)));
      chk("post_lane2_val", 128'(CDB_value[95:64]), 128'(f_val(20, 2)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
